// File: rtl/int_rr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : int_rr_sched
// Purpose  : APB-configurable interrupt scheduler; highest priority wins,
//            equal priorities rotate round-robin, grant held until ack/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module int_rr_sched #(
    parameter int NUM_PERIPHS = 16,
    parameter int PRIO_WIDTH  = 4,
    parameter int TIMEOUT     = 64,
    parameter int ADDR_WIDTH  = $clog2(NUM_PERIPHS) + 1,
    parameter int DATA_WIDTH  = NUM_PERIPHS
) (
    input  logic                           pclk_i,
    input  logic                           prst_i,
    input  logic [ADDR_WIDTH-1:0]          paddr_i,
    input  logic                           pwrite_i,
    input  logic [DATA_WIDTH-1:0]          pwdata_i,
    input  logic                           penable_i,
    output logic [DATA_WIDTH-1:0]          prdata_o,
    output logic                           pready_o,
    output logic                           perror_o,
    input  logic [NUM_PERIPHS-1:0]         int_active_i,
    input  logic                           int_serviced_i,
    output logic                           int_valid_o,
    output logic [$clog2(NUM_PERIPHS)-1:0] int_to_service_o
);

    localparam int C_IW = $clog2(NUM_PERIPHS);
    localparam int C_TW = $clog2(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_MASK   = ADDR_WIDTH'(NUM_PERIPHS);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_PEND   = ADDR_WIDTH'(NUM_PERIPHS + 1);
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_STATUS = ADDR_WIDTH'(NUM_PERIPHS + 2);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GIVEN    = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PRIO_WIDTH-1:0]   prio_q [NUM_PERIPHS];
    logic [PRIO_WIDTH-1:0]   prio_d [NUM_PERIPHS];
    logic [NUM_PERIPHS-1:0]  mask_q, mask_d;
    logic                    tflag_q, tflag_d;
    logic [C_IW-1:0]         last_idx_q, last_idx_d;
    logic [C_IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [C_IW-1:0]         grant_idx_q, grant_idx_d;
    logic                    grant_vld_q, grant_vld_d;
    logic [C_TW-1:0]         timer_q, timer_d;
    logic                    pready_q, pready_d;
    logic                    perror_q, perror_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

    logic [NUM_PERIPHS-1:0]  w_elig;
    logic [PRIO_WIDTH-1:0]   w_best_prio;
    logic [C_IW-1:0]         w_sel_idx;
    logic [C_IW-1:0]         w_cand;
    logic                    w_access;
    logic                    w_tflag_clr;

    // Search order starts just after rr_ptr; strict '>' keeps the first hit on ties.
    always_comb begin
        w_best_prio = '0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_PERIPHS; k++) begin
            w_elig[k] = int_active_i[k] & mask_q[k] & (prio_q[k] != '0);
        end
        for (int i = 1; i <= NUM_PERIPHS; i++) begin
            w_cand = rr_ptr_q + C_IW'(i);
            if (w_elig[w_cand] && (prio_q[w_cand] > w_best_prio)) begin
                w_best_prio = prio_q[w_cand];
                w_sel_idx   = w_cand;
            end
        end
    end

    assign w_access = penable_i & ~pready_q;

    always_comb begin
        pready_d    = w_access;
        prdata_d    = '0;
        perror_d    = 1'b0;
        prio_d      = prio_q;
        mask_d      = mask_q;
        w_tflag_clr = 1'b0;
        if (w_access) begin
            if (paddr_i < C_ADDR_MASK) begin
                if (pwrite_i) prio_d[paddr_i[C_IW-1:0]] = pwdata_i[PRIO_WIDTH-1:0];
                else          prdata_d = DATA_WIDTH'(prio_q[paddr_i[C_IW-1:0]]);
            end else if (paddr_i == C_ADDR_MASK) begin
                if (pwrite_i) mask_d   = NUM_PERIPHS'(pwdata_i);
                else          prdata_d = DATA_WIDTH'(mask_q);
            end else if (paddr_i == C_ADDR_PEND) begin
                if (pwrite_i) perror_d = 1'b1;
                else          prdata_d = DATA_WIDTH'(int_active_i & mask_q);
            end else if (paddr_i == C_ADDR_STATUS) begin
                if (pwrite_i) begin
                    w_tflag_clr = pwdata_i[DATA_WIDTH-1];
                end else begin
                    prdata_d                 = DATA_WIDTH'(last_idx_q);
                    prdata_d[DATA_WIDTH-1]   = tflag_q;
                end
            end else begin
                perror_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_vld_d = grant_vld_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        tflag_d     = tflag_q & ~w_tflag_clr;
        case (state_q)
            S_IDLE: begin
                if (|w_elig) begin
                    grant_vld_d = 1'b1;
                    grant_idx_d = w_sel_idx;
                    last_idx_d  = w_sel_idx;
                    timer_d     = '0;
                    state_d     = S_GIVEN;
                end
            end
            S_GIVEN: begin
                // Ack has priority over a simultaneous timeout expiry.
                if (int_serviced_i) begin
                    grant_vld_d = 1'b0;
                    rr_ptr_d    = grant_idx_q;
                    state_d     = S_COOLDOWN;
                end else if (timer_q == C_TW'(TIMEOUT - 1)) begin
                    grant_vld_d = 1'b0;
                    tflag_d     = 1'b1;
                    rr_ptr_d    = grant_idx_q;
                    state_d     = S_COOLDOWN;
                end else begin
                    timer_d = timer_q + C_TW'(1);
                end
            end
            S_COOLDOWN: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < NUM_PERIPHS; k++) prio_q[k] <= '0;
            mask_q      <= '1;
            tflag_q     <= 1'b0;
            last_idx_q  <= '0;
            rr_ptr_q    <= C_IW'(NUM_PERIPHS - 1);
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            timer_q     <= '0;
            pready_q    <= 1'b0;
            perror_q    <= 1'b0;
            prdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            mask_q      <= mask_d;
            tflag_q     <= tflag_d;
            last_idx_q  <= last_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            grant_vld_q <= grant_vld_d;
            timer_q     <= timer_d;
            pready_q    <= pready_d;
            perror_q    <= perror_d;
            prdata_q    <= prdata_d;
        end
    end

    assign prdata_o         = prdata_q;
    assign pready_o         = pready_q;
    assign perror_o         = perror_q;
    assign int_valid_o      = grant_vld_q;
    assign int_to_service_o = grant_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_int_rr_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_int_rr_sched
// Purpose  : Scoreboard bench for int_rr_sched; APB and grant expectations are
//            queued by stimulus and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_rr_sched;

    localparam int N  = 16;
    localparam int PW = 4;
    localparam int TO = 64;
    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          prst = 1'b1;
    logic [AW-1:0] paddr = '0;
    logic          pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic          penable = 1'b0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          perror;
    logic [N-1:0]  int_active = '0;
    logic          int_serviced = 1'b0;
    logic          int_valid;
    logic [3:0]    int_to_service;

    int_rr_sched #(
        .NUM_PERIPHS(N), .PRIO_WIDTH(PW), .TIMEOUT(TO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .pclk_i(clk), .prst_i(prst), .paddr_i(paddr), .pwrite_i(pwrite),
        .pwdata_i(pwdata), .penable_i(penable), .prdata_o(prdata),
        .pready_o(pready), .perror_o(perror), .int_active_i(int_active),
        .int_serviced_i(int_serviced), .int_valid_o(int_valid),
        .int_to_service_o(int_to_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } apb_exp_t;

    apb_exp_t apb_q[$];
    int       grant_q[$];
    int       checks = 0;
    int       errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    initial begin : monitor
        apb_exp_t e;
        int       g;
        logic     prev_v;
        prev_v = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pready) begin
                if (apb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL apb_unexpected: pready with empty queue at %0t", $time);
                end else begin
                    e = apb_q.pop_front();
                    check("apb_rdata", prdata, e.data);
                    check("apb_err", perror, e.err);
                end
            end
            if (int_valid && !prev_v) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: index %0d at %0t", int_to_service, $time);
                end else begin
                    g = grant_q.pop_front();
                    check("grant_idx", int_to_service, g);
                end
            end
            prev_v = int_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    task automatic apb(input int addr, input logic wr, input logic [DW-1:0] wd,
                       input logic [DW-1:0] ed, input logic ee);
        apb_exp_t e;
        e.data = ed;
        e.err  = ee;
        apb_q.push_back(e);
        @(negedge clk);
        paddr   = AW'(addr);
        pwrite  = wr;
        pwdata  = wd;
        penable = 1'b1;
        @(negedge clk);
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (!int_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, int_valid, 1);
    endtask

    task automatic ack(input logic [N-1:0] act_after);
        @(negedge clk);
        int_serviced = 1'b1;
        int_active   = act_after;
        @(negedge clk);
        int_serviced = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        prst = 1'b1;
        repeat (3) @(negedge clk);
        prst = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        logic seen;

        // Reset state and register defaults
        repeat (3) @(negedge clk);
        prst = 1'b0;
        check("rst_prdata", prdata, 0);
        check("rst_pready", pready, 0);
        check("rst_perror", perror, 0);
        check("rst_valid", int_valid, 0);
        check("rst_index", int_to_service, 0);
        apb(0, 0, 0, 16'h0000, 0);
        apb(N, 0, 0, 16'hFFFF, 0);
        apb(N + 2, 0, 0, 16'h0000, 0);

        // Strict priority: PRIO[k] = 16-k, PRIO[0] truncates to 0
        for (int k = 0; k < N; k++) apb(k, 1, 16'(16 - k), 0, 0);
        apb(0, 0, 0, 16'h0000, 0);
        apb(1, 0, 0, 16'h000F, 0);
        grant_q.push_back(4);
        grant_q.push_back(5);
        int_active = 16'h00F0;
        wait_grant("grant_4_seen");
        ack(16'h00E0);
        check("ack_low_t1", int_valid, 0);
        @(negedge clk);
        check("ack_low_t2", int_valid, 0);
        @(negedge clk);
        check("regrant_t3", int_valid, 1);
        check("regrant_idx", int_to_service, 5);
        ack(16'h0000);
        do_reset();

        // Equal priorities rotate round-robin with lines held
        apb(2, 1, 16'h3, 0, 0);
        apb(5, 1, 16'h3, 0, 0);
        apb(9, 1, 16'h3, 0, 0);
        grant_q.push_back(2);
        grant_q.push_back(5);
        grant_q.push_back(9);
        grant_q.push_back(2);
        int_active = 16'h0224;
        for (int i = 0; i < 4; i++) begin
            wait_grant("rr_grant_seen");
            @(negedge clk);
            ack((i == 3) ? 16'h0000 : 16'h0224);
        end
        apb(N + 2, 0, 0, 16'h0002, 0);

        // Timeout: grant held exactly TO cycles, sticky flag, W1C
        apb(3, 1, 16'h1, 0, 0);
        grant_q.push_back(3);
        int_active = 16'h0008;
        wait_grant("to_grant_seen");
        n = 0;
        while (int_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        int_active = 16'h0000;
        check("timeout_cycles", n, TO);
        apb(N + 2, 0, 0, 16'h8003, 0);
        apb(N + 2, 1, 16'h8000, 0, 0);
        apb(N + 2, 0, 0, 16'h0003, 0);

        // Masked source never granted; error accesses
        apb(N, 1, 16'hFFFE, 0, 0);
        apb(0, 1, 16'h7, 0, 0);
        int_active = 16'h0001;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | int_valid;
        end
        check("masked_no_grant", seen, 0);
        apb(N + 1, 0, 0, 16'h0000, 0);
        apb(N + 1, 1, 16'hFFFF, 16'h0000, 1);
        apb(N + 5, 0, 0, 16'h0000, 1);
        apb(N, 0, 0, 16'hFFFE, 0);

        // Reset in the middle of a grant
        int_active = 16'h0041;
        grant_q.push_back(6);
        apb(6, 1, 16'h5, 0, 0);
        wait_grant("pre_reset_grant_seen");
        check("pre_reset_idx", int_to_service, 6);
        @(negedge clk);
        prst = 1'b1;
        @(negedge clk);
        check("midrst_valid", int_valid, 0);
        check("midrst_index", int_to_service, 0);
        check("midrst_pready", pready, 0);
        prst = 1'b0;
        int_active = 16'h0000;
        apb(N, 0, 0, 16'hFFFF, 0);
        apb(0, 0, 0, 16'h0000, 0);
        apb(6, 0, 0, 16'h0000, 0);
        apb(N + 2, 0, 0, 16'h0000, 0);

        // PEND reflects active & mask even with all priorities zero
        int_active = 16'h0224;
        apb(N + 1, 0, 0, 16'h0224, 0);
        int_active = 16'h0000;

        repeat (5) @(negedge clk);
        check("apb_queue_drained", apb_q.size(), 0);
        check("grant_queue_drained", grant_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
